raster_to_bitplane: RTL and testbench

RASTER_TO_BITPLANE -- requirements
Module: raster_to_bitplane

---
 rtl/gpu_raster_pkg.sv | 21 ++
 rtl/raster_to_bitplane_if.sv | 41 ++++
 rtl/bitplane_slot_insert.sv | 36 +++
 rtl/raster_to_bitplane.sv | 134 +++++++++++++
 tb/tb_raster_to_bitplane.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_raster_pkg.sv
// Shared GPU raster types: colour-mode encodings, pixels-per-byte table
// and the bitplane packer state encodings.
package gpu_raster_pkg;

    typedef enum logic [1:0] {
        CM_1BPP = 2'b00,
        CM_2BPP = 2'b01,
        CM_4BPP = 2'b10,
        CM_8BPP = 2'b11
    } colour_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_HOLD
    } state_t;

    // Indexed by colour_mode_t.
    localparam logic [3:0] PIX_PER_BYTE [4] = '{4'd8, 4'd4, 4'd2, 4'd1};

endpackage

// File: rtl/raster_to_bitplane_if.sv
// Pixel stream in / RAM write stream out for raster_to_bitplane.
// slave: packer view; master: producer/RAM view. wr_mask with RASTER_TO_BITPLANE_MASK_EN.
interface raster_to_bitplane_if #(
    parameter int ADDR_W = 20
);
    logic              pix_valid;
    logic              pix_ready;
    logic [7:0]        pix_in;
    logic [7:0]        pix_in_h;
    logic              pix_last;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic [7:0]        wr_data_h;
    logic              wr_16bit;
`ifdef RASTER_TO_BITPLANE_MASK_EN
    logic [7:0]        wr_mask;
`endif

    modport slave (
`ifdef RASTER_TO_BITPLANE_MASK_EN
        output wr_mask,
`endif
        input  pix_valid, pix_in, pix_in_h, pix_last,
        output pix_ready,
        output wr_valid, wr_addr, wr_data, wr_data_h, wr_16bit,
        input  wr_ready
    );

    modport master (
`ifdef RASTER_TO_BITPLANE_MASK_EN
        input  wr_mask,
`endif
        output pix_valid, pix_in, pix_in_h, pix_last,
        input  pix_ready,
        input  wr_valid, wr_addr, wr_data, wr_data_h, wr_16bit,
        output wr_ready
    );

endinterface

// File: rtl/bitplane_slot_insert.sv
// Places one pixel into its MSB-first slot of a byte for the given mode.
// Ports: mode, slot, pix -> data (and mask with RASTER_TO_BITPLANE_MASK_EN).
module bitplane_slot_insert
    import gpu_raster_pkg::*;
(
    input  colour_mode_t mode,
    input  logic [2:0]   slot,
    input  logic [7:0]   pix,
`ifdef RASTER_TO_BITPLANE_MASK_EN
    output logic [7:0]   mask,
`endif
    output logic [7:0]   data
);

    logic [7:0] fmask;
    logic [2:0] sh;

    // Shift = 8 - bpp*(slot+1), written as an inverted slot index.
    always_comb begin
        fmask = 8'h00;
        sh    = 3'd0;
        unique case (mode)
            CM_1BPP: begin fmask = 8'h01; sh = ~slot;                 end
            CM_2BPP: begin fmask = 8'h03; sh = {~slot[1:0], 1'b0};    end
            CM_4BPP: begin fmask = 8'h0F; sh = {~slot[0], 2'b00};     end
            CM_8BPP: begin fmask = 8'hFF; sh = 3'd0;                  end
            default: ;
        endcase
    end

    assign data = (pix & fmask) << sh;
`ifdef RASTER_TO_BITPLANE_MASK_EN
    assign mask = fmask << sh;
`endif

endmodule

// File: rtl/raster_to_bitplane.sv
// Packs a raster pixel stream into bitplane bytes/words for GPU RAM writes.
// Ports: clk, rst, pc_ena, line_start, line_addr, colour_mode_in, two_byte_mode, bus (slave).
// Optional wr_mask output with RASTER_TO_BITPLANE_MASK_EN.
module raster_to_bitplane
    import gpu_raster_pkg::*;
#(
    parameter int ADDR_W = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          pc_ena,
    input  logic                line_start,
    input  logic [ADDR_W-1:0]   line_addr,
    input  logic [1:0]          colour_mode_in,
    input  logic                two_byte_mode,
    raster_to_bitplane_if.slave bus
);

    state_t            state, state_nxt;
    logic [2:0]        cnt;
    colour_mode_t      cur_mode;
    logic [7:0]        acc;
    logic [ADDR_W-1:0] nxt_addr;

    logic              adv, ls, fire, first, use_two;
    logic              complete, emit, drop;
    colour_mode_t      use_mode;
    logic [2:0]        slot;
    logic [7:0]        ins_data, acc_nxt;
    logic [ADDR_W-1:0] base;
`ifdef RASTER_TO_BITPLANE_MASK_EN
    logic [7:0]        acc_msk, ins_mask, msk_nxt;
`endif

    assign adv  = pc_ena == 4'd0;
    assign ls   = line_start && adv;
    assign drop = bus.wr_valid && bus.wr_ready && adv;
    assign fire = bus.pix_valid && bus.pix_ready;

    assign bus.wr_valid  = state == ST_HOLD;
    assign bus.pix_ready = adv && !rst && !(bus.wr_valid && !bus.wr_ready);

    // A new byte starts on a line_start or whenever nothing is accumulated;
    // mode is sampled there and held for the rest of the byte.
    assign first    = ls || state != ST_ACCUM;
    assign use_mode = first ? colour_mode_t'(colour_mode_in) : cur_mode;
    assign use_two  = first && two_byte_mode;
    assign slot     = first ? 3'd0 : cnt;

    bitplane_slot_insert u_ins (
        .mode (use_mode),
        .slot (slot),
        .pix  (bus.pix_in),
`ifdef RASTER_TO_BITPLANE_MASK_EN
        .mask (ins_mask),
`endif
        .data (ins_data)
    );

    assign acc_nxt = (first ? 8'h00 : acc) | ins_data;
`ifdef RASTER_TO_BITPLANE_MASK_EN
    assign msk_nxt = (first ? 8'h00 : acc_msk) | ins_mask;
`endif

    assign complete = use_two || bus.pix_last
                    || ({1'b0, slot} + 4'd1 == PIX_PER_BYTE[use_mode]);
    assign emit     = fire && complete;
    assign base     = ls ? line_addr : nxt_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE, ST_ACCUM: begin
                if (emit)      state_nxt = ST_HOLD;
                else if (fire) state_nxt = ST_ACCUM;
                else if (ls)   state_nxt = ST_IDLE;
            end
            ST_HOLD: begin
                if (emit)      state_nxt = ST_HOLD;
                else if (fire) state_nxt = ST_ACCUM;
                else if (drop) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= 3'd0;
            cur_mode      <= CM_1BPP;
            acc           <= 8'h00;
            nxt_addr      <= '0;
            bus.wr_addr   <= '0;
            bus.wr_data   <= 8'h00;
            bus.wr_data_h <= 8'h00;
            bus.wr_16bit  <= 1'b0;
`ifdef RASTER_TO_BITPLANE_MASK_EN
            acc_msk       <= 8'h00;
            bus.wr_mask   <= 8'h00;
`endif
        end else begin
            if (fire) cur_mode <= use_mode;
            if (emit || (ls && !fire)) begin
                cnt <= 3'd0;
                acc <= 8'h00;
            end else if (fire) begin
                cnt <= slot + 3'd1;
                acc <= acc_nxt;
            end
`ifdef RASTER_TO_BITPLANE_MASK_EN
            if (emit || (ls && !fire)) acc_msk <= 8'h00;
            else if (fire)             acc_msk <= msk_nxt;
`endif
            if (emit) begin
                bus.wr_addr   <= base;
                nxt_addr      <= base + {{(ADDR_W-2){1'b0}}, use_two, ~use_two};
                bus.wr_data   <= use_two ? bus.pix_in : acc_nxt;
                bus.wr_data_h <= use_two ? bus.pix_in_h : 8'h00;
                bus.wr_16bit  <= use_two && use_mode != CM_1BPP;
`ifdef RASTER_TO_BITPLANE_MASK_EN
                bus.wr_mask   <= use_two ? 8'hFF : msk_nxt;
`endif
            end else if (ls) begin
                nxt_addr <= line_addr;
            end
        end
    end

endmodule

// File: tb/tb_raster_to_bitplane.sv
// Directed and randomized bench for raster_to_bitplane.
// Optional wr_mask checks follow RASTER_TO_BITPLANE_MASK_EN.
module tb_raster_to_bitplane;

    localparam int AW = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    pc_ena;
    logic          line_start;
    logic [AW-1:0] line_addr;
    logic [1:0]    colour_mode_in;
    logic          two_byte_mode;

    logic          rand_en = 1'b0;
    logic          wr_ready_d = 1'b1;
    logic          rnd_ready = 1'b1;
    logic [3:0]    rnd_pc = 4'd0;

    raster_to_bitplane_if #(.ADDR_W(AW)) bus ();

    raster_to_bitplane #(.ADDR_W(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc_ena         (pc_ena),
        .line_start     (line_start),
        .line_addr      (line_addr),
        .colour_mode_in (colour_mode_in),
        .two_byte_mode  (two_byte_mode),
        .bus            (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.wr_ready = rand_en ? rnd_ready : wr_ready_d;
    assign pc_ena       = rand_en ? rnd_pc : 4'd0;

    always @(negedge clk) begin
        rnd_ready <= ($urandom_range(0, 3) != 0);
        rnd_pc    <= ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
    end

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    d;
        logic [7:0]    h;
        logic          b16;
        logic [7:0]    m;
    } wr_t;

    wr_t got_q[$];
    wr_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    // Records every write the RAM side accepts on the coming edge.
    always @(negedge clk) begin
        wr_t w;
        #2;
        if (bus.wr_valid === 1'b1 && bus.wr_ready === 1'b1 && pc_ena == 4'd0) begin
            w.addr = bus.wr_addr;
            w.d    = bus.wr_data;
            w.h    = bus.wr_data_h;
            w.b16  = bus.wr_16bit;
`ifdef RASTER_TO_BITPLANE_MASK_EN
            w.m    = bus.wr_mask;
`else
            w.m    = 8'hFF;
`endif
            got_q.push_back(w);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [7:0] d,
                            input logic [7:0] h, input logic b16, input logic [7:0] m);
        wr_t w;
        w.addr = a; w.d = d; w.h = h; w.b16 = b16; w.m = m;
        exp_q.push_back(w);
    endtask

    task automatic compare(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_addr"}, 32'(got_q[i].addr), 32'(exp_q[i].addr));
            chk({tag, "_data"}, 32'(got_q[i].d), 32'(exp_q[i].d));
            chk({tag, "_data_h"}, 32'(got_q[i].h), 32'(exp_q[i].h));
            chk({tag, "_16bit"}, 32'(got_q[i].b16), 32'(exp_q[i].b16));
`ifdef RASTER_TO_BITPLANE_MASK_EN
            chk({tag, "_mask"}, 32'(got_q[i].m), 32'(exp_q[i].m));
`endif
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] p, input logic [7:0] ph, input logic last,
                        input logic [1:0] m, input logic two,
                        input logic ls, input logic [AW-1:0] la);
        int n = 0;
        bus.pix_valid  = 1'b1;
        bus.pix_in     = p;
        bus.pix_in_h   = ph;
        bus.pix_last   = last;
        colour_mode_in = m;
        two_byte_mode  = two;
        line_start     = ls;
        line_addr      = la;
        #1;
        while (bus.pix_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("pix_accept", 32'(bus.pix_ready), 32'd1);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
        line_start    = 1'b0;
    endtask

    task automatic ls_only(input logic [AW-1:0] la);
        int n = 0;
        bus.pix_valid = 1'b0;
        line_start    = 1'b1;
        line_addr     = la;
        #1;
        while (pc_ena != 4'd0 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("ls_taken", 32'(pc_ena), 32'd0);
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (got_q.size() < exp_q.size() || bus.wr_valid); i++)
            @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int            mode, two, len, k, bpp, ppb;
        logic [7:0]    p, ph, acc;
        logic [AW-1:0] maddr, base;
        logic          last;
        logic [7:0]    pat;

        rst            = 1'b1;
        bus.pix_valid  = 1'b0;
        bus.pix_in     = 8'h00;
        bus.pix_in_h   = 8'h00;
        bus.pix_last   = 1'b0;
        line_start     = 1'b0;
        line_addr      = '0;
        colour_mode_in = 2'b00;
        two_byte_mode  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
        chk("rst_wr_data_h", 32'(bus.wr_data_h), 32'd0);
        chk("rst_wr_16bit", 32'(bus.wr_16bit), 32'd0);
        chk("rst_pix_ready", 32'(bus.pix_ready), 32'd0);
`ifdef RASTER_TO_BITPLANE_MASK_EN
        chk("rst_wr_mask", 32'(bus.wr_mask), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1bpp full byte, upper pixel bits must be ignored
        ls_only(20'h100);
        pat = 8'b1011_0010;
        for (int i = 0; i < 8; i++)
            send((8'($urandom) & 8'hFE) | {7'd0, pat[7-i]}, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, '0);
        #1;
        chk("a_latency_valid", 32'(bus.wr_valid), 32'd1);
        drain();
        push_exp(20'h100, 8'hB2, 8'h00, 1'b0, 8'hFF);
        compare("a_1bpp");

        // 2bpp two bytes
        ls_only(20'h100);
        send(8'h03, 8'h00, 1'b0, 2'b01, 1'b0, 1'b0, '0);
        send(8'h00, 8'h00, 1'b0, 2'b01, 1'b0, 1'b0, '0);
        send(8'h02, 8'h00, 1'b0, 2'b01, 1'b0, 1'b0, '0);
        send(8'h01, 8'h00, 1'b0, 2'b01, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++)
            send(8'hFD, 8'h00, 1'b0, 2'b01, 1'b0, 1'b0, '0);
        drain();
        push_exp(20'h100, 8'hC9, 8'h00, 1'b0, 8'hFF);
        push_exp(20'h101, 8'h55, 8'h00, 1'b0, 8'hFF);
        compare("b_2bpp");

        // 4bpp with pix_last on a partial byte
        ls_only(20'h200);
        send(8'h0A, 8'h00, 1'b0, 2'b10, 1'b0, 1'b0, '0);
        send(8'h05, 8'h00, 1'b0, 2'b10, 1'b0, 1'b0, '0);
        send(8'h0F, 8'h00, 1'b1, 2'b10, 1'b0, 1'b0, '0);
        drain();
        push_exp(20'h200, 8'hA5, 8'h00, 1'b0, 8'hFF);
        push_exp(20'h201, 8'hF0, 8'h00, 1'b0, 8'hF0);
        compare("c_4bpp_last");

        // Word mode with back-pressure
        wr_ready_d = 1'b0;
        ls_only(20'h300);
        send(8'h34, 8'h12, 1'b0, 2'b11, 1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("d_hold_valid", 32'(bus.wr_valid), 32'd1);
            chk("d_hold_addr", 32'(bus.wr_addr), 32'h300);
            chk("d_hold_data", 32'(bus.wr_data), 32'h34);
            chk("d_hold_data_h", 32'(bus.wr_data_h), 32'h12);
            chk("d_hold_16bit", 32'(bus.wr_16bit), 32'd1);
            chk("d_hold_pix_ready", 32'(bus.pix_ready), 32'd0);
            @(negedge clk);
        end
        wr_ready_d = 1'b1;
        @(negedge clk);
        send(8'h56, 8'h78, 1'b0, 2'b11, 1'b1, 1'b0, '0);
        drain();
        push_exp(20'h300, 8'h34, 8'h12, 1'b1, 8'hFF);
        push_exp(20'h302, 8'h56, 8'h78, 1'b1, 8'hFF);
        compare("d_word");

        // line_start in ACCUM discards the partial byte
        ls_only(20'h400);
        for (int i = 0; i < 5; i++)
            send(8'h01, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, '0);
        ls_only(20'h500);
        for (int i = 0; i < 8; i++)
            send(8'(i % 2), 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, '0);
        drain();
        push_exp(20'h500, 8'h55, 8'h00, 1'b0, 8'hFF);
        compare("e_ls_accum");

        // line_start together with a pixel: slot 0 at line_addr
        for (int i = 0; i < 3; i++)
            send(8'h01, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, '0);
        send(8'h01, 8'h00, 1'b0, 2'b00, 1'b0, 1'b1, 20'h600);
        for (int i = 0; i < 7; i++)
            send(8'(i == 6), 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, '0);
        drain();
        push_exp(20'h600, 8'h81, 8'h00, 1'b0, 8'hFF);
        compare("f_ls_with_pix");

        // line_start during HOLD keeps the held write
        wr_ready_d = 1'b0;
        ls_only(20'h700);
        send(8'hAB, 8'h00, 1'b0, 2'b11, 1'b0, 1'b0, '0);
        ls_only(20'h800);
        #1;
        chk("g_hold_addr", 32'(bus.wr_addr), 32'h700);
        @(negedge clk);
        wr_ready_d = 1'b1;
        send(8'hCD, 8'h00, 1'b0, 2'b11, 1'b0, 1'b0, '0);
        drain();
        push_exp(20'h700, 8'hAB, 8'h00, 1'b0, 8'hFF);
        push_exp(20'h800, 8'hCD, 8'h00, 1'b0, 8'hFF);
        compare("g_ls_hold");

        // Reset during HOLD
        wr_ready_d = 1'b0;
        ls_only(20'h900);
        send(8'hEE, 8'h00, 1'b0, 2'b11, 1'b0, 1'b0, '0);
        rst = 1'b1;
        #1;
        chk("h_rst_valid", 32'(bus.wr_valid), 32'd0);
        chk("h_rst_ready", 32'(bus.pix_ready), 32'd0);
        chk("h_rst_addr", 32'(bus.wr_addr), 32'd0);
        chk("h_rst_data", 32'(bus.wr_data), 32'd0);
        @(negedge clk);
        wr_ready_d = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drain();
        compare("h_rst_hold");

        // Random lines with pc_ena and wr_ready stalls
        rand_en = 1'b1;
        for (int ln = 0; ln < 10; ln++) begin
            mode  = $urandom_range(0, 3);
            two   = ($urandom_range(0, 3) == 0);
            len   = $urandom_range(1, 19);
            base  = (ln == 0) ? 20'hFFFFD : AW'($urandom);
            maddr = base;
            k     = 0;
            acc   = 8'h00;
            bpp   = 1 << mode;
            ppb   = 8 / bpp;
            ls_only(base);
            for (int i = 0; i < len; i++) begin
                p    = 8'($urandom);
                ph   = 8'($urandom);
                last = (i == len - 1);
                if (two != 0) begin
                    send(p, ph, last, 2'(mode), 1'b1, 1'b0, '0);
                    push_exp(maddr, p, ph, mode != 0, 8'hFF);
                    maddr = maddr + AW'(2);
                end else begin
                    if (k == 0)
                        send(p, ph, last, 2'(mode), 1'b0, 1'b0, '0);
                    else
                        send(p, ph, last, 2'($urandom), 1'($urandom), 1'b0, '0);
                    acc = acc | 8'((32'(p) & ((1 << bpp) - 1)) << (8 - bpp * (k + 1)));
                    k++;
                    if (k == ppb || last) begin
                        push_exp(maddr, acc, 8'h00, 1'b0, 8'(255 << (8 - bpp * k)));
                        maddr = maddr + AW'(1);
                        k     = 0;
                        acc   = 8'h00;
                    end
                end
            end
            drain();
            compare("rnd_line");
        end
        rand_en = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
